// File: rtl/acc_tree_stream.sv
// acc_tree_stream: pipelined lane-sum tree feeding a saturating row accumulator.
// Valid/ready stream; the bypass operand travels alongside with matched latency.
module acc_tree_stream #(
  parameter int N_LANES   = 64,
  parameter int DATA_W    = 16,
  parameter int FRAC      = 10,
  parameter int ACC_W     = 32,
  parameter int SEG_LANES = 16,
  parameter int LEN_W     = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [LEN_W-1:0]                      i_length_mode,
  input  logic [N_LANES*DATA_W-1:0]             i_in0_flat,
  input  logic [N_LANES*DATA_W-1:0]             i_in1_flat,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [ACC_W-1:0]                      o_global_sum,
  output logic [(N_LANES/SEG_LANES)*ACC_W-1:0]  o_seg_flat,
  output logic [ACC_W-1:0]                      o_beat_sum,
  output logic [LEN_W-1:0]                      o_length_mode_byp,
  output logic [LEN_W-1:0]                      o_beat_idx,
  output logic                                  o_last,
  output logic                                  o_sat,
  output logic [N_LANES*DATA_W-1:0]             o_in0_byp
);

  localparam int LVL   = $clog2(N_LANES);
  localparam int SL    = $clog2(SEG_LANES);
  localparam int NSEG  = N_LANES / SEG_LANES;
  localparam int NODES = 2 * N_LANES - 1;
  localparam int W     = N_LANES * DATA_W;
  localparam int SEGW  = NSEG * ACC_W;
  localparam int SD    = LVL - SL;

  typedef enum logic {IDLE, IN_ROW} st_e;

  // first node of tree level l in the flat node array
  function automatic int off(input int l);
    return 2 * N_LANES - ((2 * N_LANES) >> l);
  endfunction

  if (FRAC >= DATA_W || ACC_W < DATA_W + LVL ||
      (1 << LVL) != N_LANES || N_LANES < 4 ||
      (1 << SL) != SEG_LANES || SEG_LANES > N_LANES) begin : g_cfg_err
    $error("acc_tree_stream: illegal parameter set");
  end

  logic                    adv;
  logic signed [ACC_W-1:0] node_q [NODES];
  logic                    v_q    [LVL+1];
  logic [LEN_W-1:0]        len_q  [LVL+1];
  logic [W-1:0]            byp_q  [LVL+1];
  logic [SEGW-1:0]         seg_src;
  logic [SEGW-1:0]         seg_top;

  st_e              st_q;
  logic             valid_q;
  logic             last_q;
  logic             sat_q;
  logic [ACC_W-1:0] gsum_q;
  logic [ACC_W-1:0] beat_q;
  logic [SEGW-1:0]  seg_q;
  logic [LEN_W-1:0] len_o_q;
  logic [LEN_W-1:0] idx_q;
  logic [W-1:0]     in0_q;

  logic [ACC_W-1:0] base_d;
  logic [ACC_W-1:0] beat_w;
  logic [ACC_W-1:0] gsum_d;
  logic [ACC_W:0]   wide;
  logic             ovf;
  logic             sat_in;
  logic             sat_d;
  logic             last_d;
  logic [LEN_W-1:0] idx_d;
  logic [LEN_W-1:0] len_d;

  assign adv     = i_en & ~(valid_q & ~i_ready);
  assign o_ready = adv;

  // input register plus one register per tree level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NODES; i++) node_q[i] <= '0;
      for (int l = 0; l <= LVL; l++) begin
        v_q[l]   <= 1'b0;
        len_q[l] <= '0;
        byp_q[l] <= '0;
      end
    end else if (adv) begin
      v_q[0]   <= i_valid;
      len_q[0] <= i_length_mode;
      byp_q[0] <= i_in0_flat;
      for (int k = 0; k < N_LANES; k++)
        node_q[k] <= ACC_W'($signed(i_in1_flat[k*DATA_W +: DATA_W]));
      for (int l = 1; l <= LVL; l++) begin
        v_q[l]   <= v_q[l-1];
        len_q[l] <= len_q[l-1];
        byp_q[l] <= byp_q[l-1];
        for (int k = 0; k < (N_LANES >> l); k++)
          node_q[off(l)+k] <= node_q[off(l-1)+2*k] + node_q[off(l-1)+2*k+1];
      end
    end
  end

  // segment sums are the nodes of tree level SL
  always_comb begin
    seg_src = '0;
    for (int j = 0; j < NSEG; j++)
      seg_src[j*ACC_W +: ACC_W] = node_q[off(SL)+j];
  end

  if (SD == 0) begin : g_seg_direct
    assign seg_top = seg_src;
  end else begin : g_seg_delay
    logic [SEGW-1:0] segd_q [SD];
    // delay segment sums up to the top of the tree
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < SD; i++) segd_q[i] <= '0;
      end else if (adv) begin
        segd_q[0] <= seg_src;
        for (int i = 1; i < SD; i++) segd_q[i] <= segd_q[i-1];
      end
    end
    assign seg_top = segd_q[SD-1];
  end

  assign beat_w = node_q[NODES-1];

  // row-state dependent operands of the accumulator add
  always_comb begin
    base_d = '0;
    idx_d  = '0;
    len_d  = len_q[LVL];
    sat_in = 1'b0;
    unique case (st_q)
      IDLE: ;
      IN_ROW: begin
        base_d = gsum_q;
        idx_d  = idx_q + LEN_W'(1);
        len_d  = len_o_q;
        sat_in = sat_q;
      end
      default: ;
    endcase
  end

  assign wide   = {base_d[ACC_W-1], base_d} + {beat_w[ACC_W-1], beat_w};
  assign ovf    = wide[ACC_W] ^ wide[ACC_W-1];
  assign gsum_d = ovf ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}}
                      : wide[ACC_W-1:0];
  assign sat_d  = sat_in | ovf;
  assign last_d = (idx_d == len_d);

  // accumulator stage: row FSM and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q    <= IDLE;
      valid_q <= 1'b0;
      gsum_q  <= '0;
      beat_q  <= '0;
      seg_q   <= '0;
      len_o_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
      in0_q   <= '0;
    end else if (adv) begin
      valid_q <= v_q[LVL];
      if (v_q[LVL]) begin
        gsum_q  <= gsum_d;
        beat_q  <= beat_w;
        seg_q   <= seg_top;
        len_o_q <= len_d;
        idx_q   <= idx_d;
        last_q  <= last_d;
        sat_q   <= sat_d;
        in0_q   <= byp_q[LVL];
        st_q    <= last_d ? IDLE : IN_ROW;
      end
    end
  end

  assign o_valid           = valid_q;
  assign o_global_sum      = gsum_q;
  assign o_seg_flat        = seg_q;
  assign o_beat_sum        = beat_q;
  assign o_length_mode_byp = len_o_q;
  assign o_beat_idx        = idx_q;
  assign o_last            = last_q;
  assign o_sat             = sat_q;
  assign o_in0_byp         = in0_q;

endmodule

// File: tb/tb_acc_tree_stream.sv
// tb_acc_tree_stream: directed and random stream stimulus for acc_tree_stream,
// checked against a row-sum scoreboard built from plain integer arithmetic.
module tb_acc_tree_stream;

  localparam int N    = 64;
  localparam int DW   = 16;
  localparam int AW   = 24;
  localparam int SEGL = 16;
  localparam int LW   = 4;
  localparam int NS   = N / SEGL;
  localparam int W    = N * DW;
  localparam int SNW  = 1 + AW + NS*AW + AW + LW + LW + 1 + 1 + W;
  localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW-1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b1;
  logic              vin = 1'b0;
  logic              rdy_o;
  logic [LW-1:0]     mode = '0;
  logic [W-1:0]      in0 = '0;
  logic [W-1:0]      in1 = '0;
  logic              vout;
  logic              rdy_i = 1'b1;
  logic [AW-1:0]     gsum;
  logic [NS*AW-1:0]  segf;
  logic [AW-1:0]     bsum;
  logic [LW-1:0]     lenb;
  logic [LW-1:0]     bidx;
  logic              lastf;
  logic              satf;
  logic [W-1:0]      in0b;

  always #5 clk = ~clk;

  acc_tree_stream #(
    .N_LANES(N), .DATA_W(DW), .FRAC(10), .ACC_W(AW),
    .SEG_LANES(SEGL), .LEN_W(LW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_valid(vin), .o_ready(rdy_o),
    .i_length_mode(mode), .i_in0_flat(in0), .i_in1_flat(in1),
    .o_valid(vout), .i_ready(rdy_i),
    .o_global_sum(gsum), .o_seg_flat(segf), .o_beat_sum(bsum),
    .o_length_mode_byp(lenb), .o_beat_idx(bidx),
    .o_last(lastf), .o_sat(satf), .o_in0_byp(in0b)
  );

  typedef struct packed {
    logic [W-1:0]     in0;
    logic [NS*64-1:0] seg;
    longint           gsum;
    longint           beat;
    int               len;
    int               idx;
    int               t;
    logic             last;
    logic             sat;
    logic             lchk;
  } exp_t;

  exp_t           q[$];
  int             n_asr = 0;
  int             n_fail = 0;
  int             cyc = 0;
  int             pos = 0;
  int             rlen = 0;
  longint         racc = 0;
  bit             rsat = 0;
  bit             lat_chk = 1;
  bit             frz = 0;
  logic [SNW-1:0] prv;
  longint         l_gsum;
  longint         l_seg[NS];
  bit             l_last;
  bit             l_sat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs[63:0]=%h exp[63:0]=%h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [W-1:0] fill(input logic [DW-1:0] v);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [SNW-1:0] snap();
    return {vout, gsum, segf, bsum, lenb, bidx, lastf, satf, in0b};
  endfunction

  // reference: row sums as plain integers, clamped after every beat
  task automatic model_accept(input logic [LW-1:0] m,
                              input logic [W-1:0] d1,
                              input logic [W-1:0] d0);
    exp_t   e;
    longint lane;
    longint b;
    longint s[NS];
    b = 0;
    for (int j = 0; j < NS; j++) s[j] = 0;
    for (int k = 0; k < N; k++) begin
      lane = longint'($signed(d1[k*DW +: DW]));
      b += lane;
      s[k/SEGL] += lane;
    end
    if (pos == 0) begin
      rlen = int'(m);
      racc = 0;
      rsat = 0;
    end
    racc += b;
    if (racc > MAXV) begin
      racc = MAXV;
      rsat = 1;
    end else if (racc < MINV) begin
      racc = MINV;
      rsat = 1;
    end
    e.in0  = d0;
    for (int j = 0; j < NS; j++) e.seg[j*64 +: 64] = s[j];
    e.gsum = racc;
    e.beat = b;
    e.len  = rlen;
    e.idx  = pos;
    e.t    = cyc;
    e.last = (pos == rlen);
    e.sat  = rsat;
    e.lchk = lat_chk;
    pos = e.last ? 0 : pos + 1;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_valid", vout, 0);
      return;
    end
    e = q.pop_front();
    chk("gsum", $signed(gsum), e.gsum);
    chk("beat", $signed(bsum), e.beat);
    for (int j = 0; j < NS; j++)
      chk($sformatf("seg%0d", j), $signed(segf[j*AW +: AW]),
          $signed(e.seg[j*64 +: 64]));
    chk("len", lenb, e.len);
    chk("idx", bidx, e.idx);
    chk("last", lastf, e.last);
    chk("sat", satf, e.sat);
    chkw("in0_byp", in0b, e.in0);
    if (e.lchk) chk("latency", cyc - e.t, 8);
    l_gsum = $signed(gsum);
    for (int j = 0; j < NS; j++) l_seg[j] = $signed(segf[j*AW +: AW]);
    l_last = lastf;
    l_sat  = satf;
  endtask

  // one clock: drive at negedge, check outputs, account handshakes
  task automatic cycle(input logic v, input logic [LW-1:0] m,
                       input logic [W-1:0] d1, input logic [W-1:0] d0,
                       input logic r, input logic e);
    logic [SNW-1:0] cur;
    cyc++;
    vin = v; mode = m; in1 = d1; in0 = d0; rdy_i = r; en = e;
    #1;
    cur = snap();
    if (frz) begin
      n_asr++;
      assert (cur === prv) else begin
        n_fail++;
        $error("FAIL hold obs=%h exp=%h", cur[SNW-1 -: 64], prv[SNW-1 -: 64]);
      end
    end
    chk("o_ready", rdy_o, e & ~(vout & ~r));
    if (vout && r && e) pop_check();
    if (v && rdy_o) model_accept(m, d1, d0);
    frz = !e || (vout && !r);
    prv = cur;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++)
      cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("drain_left", q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, vout, 0);
    chk({tag, "_gsum"}, gsum, 0);
    chk({tag, "_seg"}, (segf == '0) ? 0 : 1, 0);
    chk({tag, "_beat"}, bsum, 0);
    chk({tag, "_len"}, lenb, 0);
    chk({tag, "_idx"}, bidx, 0);
    chk({tag, "_last"}, lastf, 0);
    chk({tag, "_sat"}, satf, 0);
    chkw({tag, "_in0"}, in0b, '0);
  endtask

  initial begin
    logic [W-1:0] d1;
    logic [W-1:0] d0;
    logic [W-1:0] rv;

    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    cycle(1'b1, 4'd0, fill(16'h0100), fill(16'h1234), 1'b1, 1'b1);
    drain();
    chk("t1_gsum", l_gsum, 16384);
    chk("t1_seg0", l_seg[0], 4096);
    chk("t1_last", l_last, 1);

    for (int k = 0; k < N; k++) begin
      d1[k*DW +: DW] = DW'((k + 1) * 10);
      rv[(N-1-k)*DW +: DW] = DW'((k + 1) * 10);
    end
    cycle(1'b1, 4'd0, d1, rv, 1'b1, 1'b1);
    drain();
    chk("t2_gsum", l_gsum, 20800);
    chk("t2_seg0", l_seg[0], 1360);
    chk("t2_seg1", l_seg[1], 3920);
    chk("t2_seg2", l_seg[2], 6480);
    chk("t2_seg3", l_seg[3], 9040);

    for (int b = 0; b < 5; b++)
      cycle(1'b1, (b < 4) ? 4'd3 : 4'd0, fill(16'h0100), fill(DW'(b)),
            1'b1, 1'b1);
    drain();
    chk("t3_newrow_gsum", l_gsum, 16384);
    chk("t3_newrow_last", l_last, 1);

    for (int b = 0; b < 5; b++)
      cycle(1'b1, 4'd4, fill(16'h7FFF), '0, 1'b1, 1'b1);
    drain();
    chk("t4_pos_clamp", l_gsum, 8388607);
    chk("t4_pos_sat", l_sat, 1);
    cycle(1'b1, 4'd0, fill(16'h0100), '0, 1'b1, 1'b1);
    drain();
    chk("t4_next_sat", l_sat, 0);
    for (int b = 0; b < 5; b++)
      cycle(1'b1, 4'd4, fill(16'h8000), '0, 1'b1, 1'b1);
    drain();
    chk("t4_neg_clamp", l_gsum, -8388608);
    chk("t4_neg_sat", l_sat, 1);

    lat_chk = 0;
    for (int b = 0; b < 10; b++)
      cycle(1'b1, 4'd0, fill(DW'(b * 3 + 1)), fill(DW'(b)), 1'b1, 1'b1);
    chk("bp_valid", vout, 1);
    for (int b = 10; b < 13; b++)
      cycle(1'b1, 4'd0, fill(DW'(b * 3 + 1)), fill(DW'(b)), 1'b0, 1'b1);
    for (int b = 13; b < 16; b++)
      cycle(1'b1, 4'd0, fill(DW'(b * 3 + 1)), fill(DW'(b)), 1'b1, 1'b1);
    drain();

    cycle(1'b1, 4'd3, fill(16'h0100), fill(16'hBEEF), 1'b1, 1'b1);
    drain();
    rst_n = 1'b0;
    #1;
    chk_zero("midrow_rst");
    q.delete();
    pos = 0;
    frz = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 4'd0, fill(16'hFF00), '0, 1'b1, 1'b1);
    drain();
    chk("t6_gsum", l_gsum, -16384);
    chk("t6_last", l_last, 1);

    for (int c = 0; c < 800; c++) begin
      logic e;
      logic r;
      int   kind;
      e = ($urandom % 10) != 0;
      r = e ? (($urandom % 4) != 0) : 1'b0;
      kind = $urandom % 8;
      for (int k = 0; k < N; k++) begin
        d1[k*DW +: DW] = (kind == 0) ? 16'h7FFF :
                         (kind == 1) ? 16'h8000 : DW'($urandom);
        d0[k*DW +: DW] = DW'($urandom);
      end
      cycle(($urandom % 10) < 7, LW'($urandom), d1, d0, r, e);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asr, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_tree_stream.md
Name: acc_tree_stream

Overview:
- Parametrised, stream-handshaked successor to the softmax-denominator accumulator.
- Each accepted beat carries N_LANES signed fixed-point lanes. A pipelined adder tree reduces the beat and produces per-segment sums.
- A row accumulator adds the beat totals over a row of 1..2^LEN_W beats, saturating at ACC_W.
- Sits between the exp-approximation stage (upstream) and the normaliser/divider (downstream). A bypass operand travels alongside, latency-matched.

Parameters:
- N_LANES, 64: lanes per beat; power of 2, at least 4.
- DATA_W, 16: signed lane width (Q format with FRAC fractional bits).
- FRAC, 10: fractional bits; informational, no arithmetic effect.
- ACC_W, 32: signed width of the sum outputs; must be at least DATA_W+log2(N_LANES).
- SEG_LANES, 16: lanes per segment sum; power of 2, at most N_LANES.
- LEN_W, 4: width of the length field.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_en  in  1  global enable; 0 freezes all state
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_length_mode  in  LEN_W  beats per row minus 1; sampled on the first beat of a row
- i_in0_flat  in  N_LANES*DATA_W  bypass operand
- i_in1_flat  in  N_LANES*DATA_W  operand to be summed; lane k = bits [k*DATA_W +: DATA_W]
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the output
- o_global_sum  out  ACC_W  running row sum including this beat, saturated
- o_seg_flat  out  (N_LANES/SEG_LANES)*ACC_W  per-beat segment sums (not accumulated); segment j covers lanes j*SEG_LANES to (j+1)*SEG_LANES-1
- o_beat_sum  out  ACC_W  total of this beat alone
- o_length_mode_byp  out  LEN_W  latched length of the row
- o_beat_idx  out  LEN_W  index of this beat within its row, starting at 0
- o_last  out  1  this is the final beat of the row; o_global_sum is the complete row sum
- o_sat  out  1  sticky: saturation occurred anywhere in this row up to and including this beat
- o_in0_byp  out  N_LANES*DATA_W  i_in0_flat of the same beat

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - o_valid, o_global_sum, o_seg_flat, o_beat_sum, o_beat_idx, o_last, o_sat, o_length_mode_byp and o_in0_byp all clear to 0.
  - Pipeline valids, the row counter and the accumulator clear.
  - A reset in the middle of a row discards the row. The next accepted beat starts a new row.
- Advance and handshake:
  - advance = i_en & ~(o_valid & ~i_ready).
  - o_ready = advance. A beat is accepted when i_valid & o_ready.
  - When advance=0, every pipeline register holds and all outputs stay stable.
- Latency:
  - LAT = log2(N_LANES)+2 advancing cycles from acceptance to o_valid: one input register, one register per tree level, one accumulator register. For N_LANES=64, LAT=8.
  - Throughput is one beat per cycle.
  - Bubbles (i_valid=0) propagate as invalid stages and do not touch the accumulator.
- Tree arithmetic:
  - Lanes are sign-extended to ACC_W.
  - Tree additions are exact, with no saturation; ACC_W is sized so they cannot overflow.
  - Segment sums are taken at tree level log2(SEG_LANES) and delayed to align with o_global_sum.
- Row state machine:
  - States are IDLE and IN_ROW, tracked at the accumulator stage.
  - IDLE, valid beat arrives:
    - latch len=i_length_mode (carried through the pipe); idx=0; acc=sat(beat_sum); sat flag = overflow.
    - If len=0, emit with o_last=1 and stay in IDLE. Otherwise go to IN_ROW.
  - IN_ROW, valid beat arrives:
    - idx+1; acc=sat(acc+beat_sum); sat flag |= overflow.
    - At idx==len, emit with o_last=1 and return to IDLE.
  - i_length_mode on non-first beats of a row is ignored.
  - len=2^LEN_W-1 is legal and gives 2^LEN_W beats.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1 it clamps to that value; below -2^(ACC_W-1) it clamps to that value. Either clamp sets o_sat.
  - Later beats keep accumulating from the clamped value.
- i_en=0:
  - Freezes everything, including the row FSM.
  - o_ready=0. o_valid is held, not dropped.

Test Plan:
- Reset, then one beat, mode 0, all lanes 0x0100:
  - o_valid exactly 8 cycles after acceptance.
  - Each segment = 4096 (4.0); o_global_sum = 16384 (16.0); o_last=1; o_sat=0.
- One beat, mode 0, lane k = (k+1)*10, o_in0 = reversed data:
  - Segments = 1360/3920/6480/9040; global = 20800.
  - o_in0_byp bit-exact to the input.
- Mode 3, four back-to-back beats of 0x0100:
  - o_global_sum = 16384, 32768, 49152, 65536; o_beat_idx = 0..3; o_last only on beat 3.
  - A fifth beat carrying mode 0 starts a new row with sum 16384.
- ACC_W=24, mode 4, five beats of 0x7FFF:
  - Beat 4 sum = 8388352 with o_sat=0.
  - Beat 5 = 8388607 with o_sat=1.
  - The next row has o_sat=0.
  - Repeat with 0x8000 lanes: beat 5 clamps to -8388608.
- Backpressure: during a mode 0 stream, hold i_ready=0 for 3 cycles while o_valid=1:
  - Outputs stay stable; o_ready=0.
  - No beat is lost or duplicated; sums are correct after release.
- Assert i_rst_n=0 after beat 1 of a mode 3 row:
  - All outputs are 0 immediately.
  - The following mode 0 beat of -256 lanes gives global -16384 (-16.0) with o_last=1.
